// File: rtl/toy_fetch_req_gen.sv
// Fetch request generator: produces the fetch PC stream for the fetch queue, issues the
// matching i-cache requests, and forwards tagged responses while squashing pre-redirect ones.
module toy_fetch_req_gen #(
  parameter int                    ADDR_WIDTH          = 32,
  parameter int                    FETCH_WRITE_CHANNEL = 4,
  parameter int                    OUTSTANDING         = 4,
  parameter int                    FQ_DEPTH            = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC            = 32'h8000_0000
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      redirect_vld,
  input  logic [ADDR_WIDTH-1:0]                     redirect_pc,
  output logic                                      fq_clear,
  input  logic                                      fq_nxt_vld,
  output logic                                      fq_nxt_rdy,
  output logic [ADDR_WIDTH-1:0]                     fq_nxt_pc,
  output logic [$clog2(2*FETCH_WRITE_CHANNEL):0]    fq_nxt_num,
  input  logic [$clog2(FQ_DEPTH)-1:0]               fq_req_entry_id,
  output logic                                      ic_req_vld,
  input  logic                                      ic_req_rdy,
  output logic [ADDR_WIDTH-1:0]                     ic_req_addr,
  output logic [$clog2(OUTSTANDING)-1:0]            ic_req_tag,
  input  logic                                      ic_ack_vld,
  input  logic [$clog2(OUTSTANDING)-1:0]            ic_ack_tag,
  input  logic [ADDR_WIDTH*FETCH_WRITE_CHANNEL-1:0] ic_ack_pld,
  output logic                                      fq_ack_vld,
  output logic [$clog2(FQ_DEPTH)-1:0]               fq_ack_entry_id,
  output logic [ADDR_WIDTH*FETCH_WRITE_CHANNEL-1:0] fq_ack_pld,
  output logic                                      dbg_state
);
  localparam int OFF_W    = $clog2(FETCH_WRITE_CHANNEL) + 1;
  localparam int NUM_W    = $clog2(2*FETCH_WRITE_CHANNEL) + 1;
  localparam int BLK_BITS = $clog2(4*FETCH_WRITE_CHANNEL);
  localparam int TAG_W    = $clog2(OUTSTANDING);
  localparam int EID_W    = $clog2(FQ_DEPTH);
  localparam int PLD_W    = ADDR_WIDTH*FETCH_WRITE_CHANNEL;
  localparam logic [ADDR_WIDTH-1:0] BLK_BYTES = ADDR_WIDTH'(4*FETCH_WRITE_CHANNEL);

  typedef enum logic {PEND = 1'b0, RUN = 1'b1} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pend_pc;
  logic [ADDR_WIDTH-1:0]   seq_pc;
  logic [ADDR_WIDTH-1:0]   cur_pc;
  logic [OFF_W-1:0]        off;
  logic [OUTSTANDING-1:0]  busy;
  logic [OUTSTANDING-1:0]  stale;
  logic [EID_W-1:0]        slot_eid [OUTSTANDING];
  logic [TAG_W-1:0]        free_tag;
  logic                    any_free;
  logic                    fire;

  assign cur_pc      = (state == PEND) ? pend_pc : seq_pc;
  assign off         = cur_pc[OFF_W:1];
  assign fq_nxt_pc   = cur_pc;
  assign fq_nxt_num  = NUM_W'(2*FETCH_WRITE_CHANNEL) - NUM_W'(off);
  assign ic_req_addr = {cur_pc[ADDR_WIDTH-1:BLK_BITS], BLK_BITS'(0)};
  assign dbg_state   = state;

  // Lowest-index slot whose registered busy bit is clear; an ack this cycle frees its slot
  // only for the next cycle's allocation.
  always_comb begin
    free_tag = '0;
    any_free = 1'b0;
    for (int i = OUTSTANDING - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_tag = TAG_W'(i);
        any_free = 1'b1;
      end
    end
  end

  // Handshake: ic_req_vld offers a request whenever the queue has room and a slot is free;
  // a transfer (fire) happens exactly in cycles where ic_req_vld & ic_req_rdy, and the queue
  // sees that same cycle as an accepted fetch via fq_nxt_rdy. Nothing is held across cycles.
  assign ic_req_vld = rst_n & fq_nxt_vld & any_free;
  assign fire       = ic_req_vld & ic_req_rdy;
  assign fq_nxt_rdy = fire;
  assign fq_clear   = (state == PEND) & fire;
  assign ic_req_tag = free_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      stale <= '0;
      for (int i = 0; i < OUTSTANDING; i++) slot_eid[i] <= '0;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (fire && free_tag == TAG_W'(i)) begin
          busy[i]     <= 1'b1;
          stale[i]    <= redirect_vld;
          slot_eid[i] <= fq_req_entry_id;
        end else if (ic_ack_vld && ic_ack_tag == TAG_W'(i)) begin
          busy[i]  <= 1'b0;
          stale[i] <= 1'b0;
        end else if (redirect_vld && busy[i]) begin
          stale[i] <= 1'b1;
        end
      end
    end
  end

  // Responses from a flushed stream, or arriving alongside a redirect, are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq_ack_vld      <= 1'b0;
      fq_ack_entry_id <= '0;
      fq_ack_pld      <= '0;
    end else begin
      fq_ack_vld <= ic_ack_vld & ~stale[ic_ack_tag] & ~redirect_vld;
      if (ic_ack_vld) begin
        fq_ack_entry_id <= slot_eid[ic_ack_tag];
        fq_ack_pld      <= PLD_W'(ic_ack_pld);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PEND;
      pend_pc <= RESET_PC;
      seq_pc  <= '0;
    end else if (redirect_vld) begin
      state   <= PEND;
      pend_pc <= redirect_pc;
    end else if (fire) begin
      state  <= RUN;
      seq_pc <= ic_req_addr + BLK_BYTES;
    end
  end
endmodule

// File: tb/tb_toy_fetch_req_gen.sv
// Bench for toy_fetch_req_gen: directed scenarios plus random traffic, all checked every
// cycle against a stream/slot-table reference model.
module tb_toy_fetch_req_gen;
  localparam int AW  = 32;
  localparam int FWC = 4;
  localparam int NS  = 4;
  localparam int FQD = 128;
  localparam int TW  = 2;
  localparam int EW  = 7;
  localparam int NW  = 4;
  localparam int PW  = AW*FWC;
  localparam int BLK = 4*FWC;
  localparam logic [AW-1:0] BOOT_PC = 32'h8000_0006;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_vld = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          fq_clear;
  logic          fq_nxt_vld = 1'b0;
  logic          fq_nxt_rdy;
  logic [AW-1:0] fq_nxt_pc;
  logic [NW-1:0] fq_nxt_num;
  logic [EW-1:0] fq_req_entry_id = '0;
  logic          ic_req_vld;
  logic          ic_req_rdy = 1'b0;
  logic [AW-1:0] ic_req_addr;
  logic [TW-1:0] ic_req_tag;
  logic          ic_ack_vld = 1'b0;
  logic [TW-1:0] ic_ack_tag = '0;
  logic [PW-1:0] ic_ack_pld = '0;
  logic          fq_ack_vld;
  logic [EW-1:0] fq_ack_entry_id;
  logic [PW-1:0] fq_ack_pld;
  logic          dbg_state;

  toy_fetch_req_gen #(
    .ADDR_WIDTH(AW), .FETCH_WRITE_CHANNEL(FWC), .OUTSTANDING(NS),
    .FQ_DEPTH(FQD), .RESET_PC(BOOT_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .fq_clear(fq_clear), .fq_nxt_vld(fq_nxt_vld), .fq_nxt_rdy(fq_nxt_rdy),
    .fq_nxt_pc(fq_nxt_pc), .fq_nxt_num(fq_nxt_num), .fq_req_entry_id(fq_req_entry_id),
    .ic_req_vld(ic_req_vld), .ic_req_rdy(ic_req_rdy), .ic_req_addr(ic_req_addr),
    .ic_req_tag(ic_req_tag), .ic_ack_vld(ic_ack_vld), .ic_ack_tag(ic_ack_tag),
    .ic_ack_pld(ic_ack_pld), .fq_ack_vld(fq_ack_vld), .fq_ack_entry_id(fq_ack_entry_id),
    .fq_ack_pld(fq_ack_pld), .dbg_state(dbg_state)
  );

  // clock/reset: posedges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // reference model: slot table, fetch stream, and expected queue writes
  logic          m_busy  [NS];
  logic          m_stale [NS];
  logic [EW-1:0] m_eid   [NS];
  logic          m_pend;
  logic [AW-1:0] m_pc;
  logic [EW+PW-1:0] exp_q[$];
  logic          p_fire;
  int            p_tag;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_busy[i] = 1'b0; m_stale[i] = 1'b0; m_eid[i] = '0;
    end
    m_pend = 1'b1;
    m_pc   = BOOT_PC;
    exp_q.delete();
  endtask

  task automatic drive(input logic vld, input logic rdy, input int eid, input logic redir,
                       input logic [AW-1:0] rpc, input logic ackv, input int ackt);
    fq_nxt_vld      = vld;
    ic_req_rdy      = rdy;
    fq_req_entry_id = EW'(eid);
    redirect_vld    = redir;
    redirect_pc     = rpc;
    ic_ack_vld      = ackv;
    ic_ack_tag      = TW'(ackt);
    ic_ack_pld      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // compare at mid-cycle, inputs having been driven at posedge+1
  task automatic probe();
    int            ft;
    logic          hf;
    logic          e_req;
    logic          e_fire;
    int            off_hw;
    logic [AW-1:0] e_addr;
    logic [NW-1:0] e_num;
    logic [EW+PW-1:0] e;
    #4;
    ft = 0; hf = 1'b0;
    for (int i = 0; i < NS; i++) if (!m_busy[i] && !hf) begin ft = i; hf = 1'b1; end
    e_req  = fq_nxt_vld && hf;
    e_fire = e_req && ic_req_rdy;
    chk("ic_req_vld", ic_req_vld, e_req);
    chk("fq_nxt_rdy", fq_nxt_rdy, e_fire);
    chk("fq_clear", fq_clear, m_pend && e_fire);
    chk("dbg_state", dbg_state, !m_pend);
    if (e_req) begin
      off_hw = int'(m_pc % BLK) / 2;
      e_num  = NW'(2*FWC - off_hw);
      e_addr = (m_pc / BLK) * BLK;
      chk("fq_nxt_pc", fq_nxt_pc, m_pc);
      chk("fq_nxt_num", fq_nxt_num, e_num);
      chk("ic_req_addr", ic_req_addr, e_addr);
      chk("ic_req_tag", ic_req_tag, ft);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fq_ack_vld", fq_ack_vld, 1'b1);
      chk("fq_ack_entry_id", fq_ack_entry_id, e[EW+PW-1:PW]);
      chk("fq_ack_pld", fq_ack_pld, e[PW-1:0]);
    end else begin
      chk("fq_ack_vld", fq_ack_vld, 1'b0);
    end
    p_fire = e_fire;
    p_tag  = ft;
  endtask

  // advance the model by one clock using this cycle's inputs, then move to posedge+1
  task automatic commit();
    if (ic_ack_vld) begin
      assert (m_busy[ic_ack_tag]) else $error("ack on idle slot %0d", ic_ack_tag);
      if (!m_stale[ic_ack_tag] && !redirect_vld)
        exp_q.push_back({m_eid[ic_ack_tag], ic_ack_pld});
      m_busy[ic_ack_tag] = 1'b0;
    end
    if (p_fire) begin
      m_busy[p_tag] = 1'b1; m_stale[p_tag] = 1'b0; m_eid[p_tag] = fq_req_entry_id;
    end
    if (redirect_vld) begin
      for (int i = 0; i < NS; i++) if (m_busy[i]) m_stale[i] = 1'b1;
      m_pend = 1'b1;
      m_pc   = redirect_pc;
    end else if (p_fire) begin
      m_pend = 1'b0;
      m_pc   = (m_pc / BLK) * BLK + BLK;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int busy_list[$];
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // boot
    drive(1, 1, 0, 0, '0, 0, 0); probe();
    chk("boot_clear", fq_clear, 1'b1);
    chk("boot_pc", fq_nxt_pc, 32'h8000_0006);
    chk("boot_num", fq_nxt_num, 4'd5);
    chk("boot_addr", ic_req_addr, 32'h8000_0000);
    chk("boot_tag", ic_req_tag, 2'd0);
    commit();
    drive(1, 1, 5, 0, '0, 0, 0); probe();
    chk("seq_pc", fq_nxt_pc, 32'h8000_0010);
    chk("seq_num", fq_nxt_num, 4'd8);
    chk("seq_clear", fq_clear, 1'b0);
    commit();
    drive(1, 1, 13, 0, '0, 0, 0); probe(); commit();
    drive(1, 1, 21, 0, '0, 0, 0); probe(); commit();

    // all slots busy, then out-of-order returns
    drive(1, 1, 30, 0, '0, 0, 0); probe();
    chk("full_no_req", ic_req_vld, 1'b0);
    commit();
    drive(0, 1, 0, 0, '0, 1, 2); probe(); commit();
    drive(0, 1, 0, 0, '0, 1, 0); probe();
    chk("ooo_vld_a", fq_ack_vld, 1'b1);
    chk("ooo_eid_a", fq_ack_entry_id, 7'd13);
    commit();
    drive(0, 1, 0, 0, '0, 0, 0); probe();
    chk("ooo_vld_b", fq_ack_vld, 1'b1);
    chk("ooo_eid_b", fq_ack_entry_id, 7'd0);
    commit();

    // redirect flush with three outstanding
    drive(1, 1, 40, 0, '0, 0, 0); probe();
    chk("refill_tag", ic_req_tag, 2'd0);
    commit();
    drive(0, 1, 0, 1, 32'h8000_0102, 0, 0); probe(); commit();
    drive(0, 1, 0, 0, '0, 1, 1); probe(); commit();
    drive(0, 1, 0, 0, '0, 1, 3); probe();
    chk("flush_drop_1", fq_ack_vld, 1'b0);
    commit();
    drive(0, 1, 0, 0, '0, 1, 0); probe();
    chk("flush_drop_3", fq_ack_vld, 1'b0);
    commit();
    drive(1, 1, 50, 0, '0, 0, 0); probe();
    chk("flush_drop_0", fq_ack_vld, 1'b0);
    chk("redir_clear", fq_clear, 1'b1);
    chk("redir_pc", fq_nxt_pc, 32'h8000_0102);
    chk("redir_num", fq_nxt_num, 4'd7);
    commit();

    // redirect coinciding with a live ack
    drive(0, 1, 0, 1, 32'h8000_0200, 1, 0); probe(); commit();
    drive(1, 1, 60, 0, '0, 0, 0); probe();
    chk("redir_ack_drop", fq_ack_vld, 1'b0);
    chk("redir_ack_freed", ic_req_tag, 2'd0);
    commit();

    // backpressure in PEND, second redirect during the stall wins
    drive(0, 1, 0, 1, 32'h8000_0300, 0, 0); probe(); commit();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 70, (k == 2), 32'h8000_0402, 0, 0); probe();
      chk("stall_clear", fq_clear, 1'b0);
      chk("stall_rdy", fq_nxt_rdy, 1'b0);
      commit();
    end
    drive(1, 1, 70, 0, '0, 0, 0); probe();
    chk("stall_done_clear", fq_clear, 1'b1);
    chk("stall_done_pc", fq_nxt_pc, 32'h8000_0402);
    commit();
    drive(1, 0, 71, 0, '0, 0, 0); probe();
    chk("single_clear", fq_clear, 1'b0);
    commit();

    // async reset with two requests outstanding
    drive(1, 1, 0, 0, '0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_nxt_rdy", fq_nxt_rdy, 1'b0);
    chk("rst_req_vld", ic_req_vld, 1'b0);
    chk("rst_clear", fq_clear, 1'b0);
    chk("rst_ack_vld", fq_ack_vld, 1'b0);
    chk("rst_ack_eid", fq_ack_entry_id, 7'd0);
    chk("rst_ack_pld", fq_ack_pld, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1, 1, 0, 0, '0, 0, 0); probe();
    chk("reboot_clear", fq_clear, 1'b1);
    chk("reboot_pc", fq_nxt_pc, 32'h8000_0006);
    chk("reboot_tag", ic_req_tag, 2'd0);
    commit();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      int at;
      logic av;
      busy_list.delete();
      for (int i = 0; i < NS; i++) if (m_busy[i]) busy_list.push_back(i);
      av = 1'b0; at = 0;
      if (busy_list.size() > 0 && $urandom_range(0, 9) < 4) begin
        av = 1'b1;
        at = busy_list[$urandom_range(0, busy_list.size() - 1)];
      end
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7), $urandom_range(0, FQD-1),
            ($urandom_range(0, 29) == 0), AW'($urandom) & ~32'h1, av, at);
      probe();
      commit();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/toy_fetch_req_gen.md
Name: toy_fetch_req_gen

Overview:
Fetch request generator that sits directly upstream of the fetch queue.
- Produces the sequential/redirected fetch PC stream and the per-fetch halfword count into the queue's pre-allocate port.
- Issues the matching instruction-cache request and tracks outstanding requests in a small tag table.
- Forwards cache responses to the queue write port, tagged with the queue entry id captured at issue; squashes responses that belong to a flushed (pre-redirect) stream.

Parameters:
- ADDR_WIDTH, 32, PC/address width (toy_pack value).
- FETCH_WRITE_CHANNEL, 4, 32-bit words per fetch block (block = 4*FETCH_WRITE_CHANNEL bytes = 16B).
- OUTSTANDING, 4, max in-flight cache requests (power of 2).
- FQ_DEPTH, 128, fetch-queue depth; sets the entry-id width.
- RESET_PC, 32'h8000_0000, first fetch PC after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- redirect_vld  in  1  backend redirect pulse
- redirect_pc  in  ADDR_WIDTH  redirect target (halfword aligned)
- fq_clear  out  1  queue clear; high only in the cycle a redirect fetch is accepted
- fq_nxt_vld  in  1  queue can accept a fetch
- fq_nxt_rdy  out  1  fetch offered/accepted this cycle
- fq_nxt_pc  out  ADDR_WIDTH  fetch PC
- fq_nxt_num  out  $clog2(2*FETCH_WRITE_CHANNEL)+1  halfwords in this fetch
- fq_req_entry_id  in  $clog2(FQ_DEPTH)  queue entry id allocated to the current fetch
- ic_req_vld  out  1  cache request valid
- ic_req_rdy  in  1  cache ready
- ic_req_addr  out  ADDR_WIDTH  block-aligned address
- ic_req_tag  out  $clog2(OUTSTANDING)  slot index
- ic_ack_vld  in  1  cache response valid (no backpressure; may return out of order)
- ic_ack_tag  in  $clog2(OUTSTANDING)  slot index of response
- ic_ack_pld  in  ADDR_WIDTH*FETCH_WRITE_CHANNEL  block data
- fq_ack_vld  out  1  write to queue
- fq_ack_entry_id  out  $clog2(FQ_DEPTH)  queue entry id
- fq_ack_pld  out  ADDR_WIDTH*FETCH_WRITE_CHANNEL  block data

Behaviour:
- Reset: state=PEND, pend_pc=RESET_PC; all slots free/not stale; fq_ack_vld=0, fq_clear=0, fq_nxt_rdy=0, ic_req_vld=0; fq_ack_entry_id=0, fq_ack_pld=0.
- Shared terms:
  - off = cur_pc[$clog2(FETCH_WRITE_CHANNEL)+1:1].
  - fq_nxt_num = 2*FETCH_WRITE_CHANNEL - off (range 1..8 at default).
  - ic_req_addr = cur_pc with low $clog2(4*FETCH_WRITE_CHANNEL) bits zeroed.
  - cur_pc = pend_pc in PEND, seq_pc in RUN.
- Issue rule, all combinational:
  - free = any slot not busy; fire = fq_nxt_vld & free & ic_req_rdy.
  - ic_req_vld = fq_nxt_vld & free; fq_nxt_rdy = fire.
  - In PEND, fq_clear = fire. The queue forces fq_nxt_vld high on clear, so the redirect fetch and the clear always coincide.
  - ic_req_tag = lowest-index free slot. On fire, that slot is set busy, not stale, with entry_id = fq_req_entry_id.
- FSM:
  - PEND --fire--> RUN, seq_pc <= aligned(pend_pc) + block size.
  - RUN --fire--> RUN, seq_pc += block size (wraps modulo 2^ADDR_WIDTH).
  - Any state --redirect_vld--> PEND, pend_pc <= redirect_pc. Redirect has priority over fire in the same cycle: that fire's slot is allocated, then immediately marked stale; fq_clear still reflects PEND-state fire only.
  - A redirect during PEND overwrites pend_pc (latest wins).
- Stale marking: on redirect_vld, every busy slot (including one allocated that cycle) gets stale=1.
- Response, registered, 1-cycle latency:
  - ic_ack_vld frees slot ic_ack_tag that cycle.
  - Next cycle, fq_ack_vld=1 with the stored entry_id and pld, only if the slot was not stale and no redirect_vld in the ack cycle; otherwise dropped (slot still freed).
- Ack and fire on the same slot in one cycle: the ack frees the slot, but the slot is not re-allocated until the next cycle (free vector is computed from the registered busy bits).
- No free slot: ic_req_vld=0 and no fetch. A pending redirect waits; the queue clear is deferred until issue.
- Ack for a non-busy slot: illegal; assertion in the bench, no RTL recovery.
- Reset mid-operation: all slots and the stream are dropped; restart from RESET_PC with a clear.

Test Plan:
- Boot: RESET_PC=0x8000_0006, fq_nxt_vld=1, ic_req_rdy=1, entry id 0 → cycle after reset: fq_clear=1, pc 0x8000_0006, num=5, addr 0x8000_0000, tag 0. Next cycle: pc 0x8000_0010, num=8, no clear.
- Out-of-order return: 4 fetches with entry ids 0,5,13,21 → acks on tags 2,0 produce fq_ack entry 13 then 0, one cycle after each ack; no 5th request issues until a slot frees.
- Redirect flush: 3 outstanding, redirect_vld to 0x8000_0102 → all 3 later acks dropped, fq_ack_vld stays 0. The next fire has fq_clear=1, pc 0x8000_0102, num=7.
- Redirect same cycle as an ack for a live slot → response dropped, slot freed.
- Backpressure: ic_req_rdy=0 for 5 cycles in PEND → no clear and no fq_nxt_rdy. Then rdy=1 → single clear with the pending pc; a second redirect during the stall wins.
- Async reset asserted with 2 outstanding → all outputs 0 immediately; after release, boot sequence repeats.
